iter_muldiv: RTL and testbench
==============================

ITER_MULDIV -- requirements
Module: iter_muldiv

Interface
REQ-001 SHALL provide parameter XLEN, default 32, meaning operand/result width (even, >= 8).
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port start  input  1  request; accepted only when busy=0.
REQ-005 SHALL provide port fun7  input  7  instruction funct7; M-extension value 7'b0000001.
REQ-006 SHALL provide port fun3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL provide ports op_a, op_b  input  XLEN  rs1 and rs2 operands.
REQ-008 SHALL provide port busy  output  1  high from acceptance until the cycle done is asserted.
REQ-009 SHALL provide port done  output  1  single-cycle completion pulse.
REQ-010 SHALL provide port result  output  XLEN  result; valid when done=1, held until next acceptance.
REQ-011 SHALL provide port illegal  output  1  qualifies done; high if the request was not a supported op.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, FIN; IDLE->CALC on accepted legal start, CALC->FIN when iteration counter reaches XLEN, FIN->IDLE unconditionally.
REQ-013 SHALL latch fun3, op_a, op_b at acceptance; input changes while busy have no effect.
REQ-014 SHALL ignore start while busy=1 (no queueing).
REQ-015 SHALL compute multiply by radix-2 shift-add, one bit per cycle, on a 2*XLEN product; MUL returns low XLEN bits, MULH/MULHSU/MULHU the high XLEN bits with signed*signed, signed*unsigned, unsigned*unsigned interpretation.
REQ-016 SHALL compute divide by restoring division, one quotient bit per cycle, on magnitudes, then apply signs: quotient negative if operand signs differ, remainder takes sign of op_a (DIV/REM only).
REQ-017 SHALL assert done exactly XLEN+1 rising edges after the acceptance edge for normal ops (XLEN=32: 33 cycles).
REQ-018 SHALL take a fast path for divide by zero: quotient all ones, remainder op_a, done 1 edge after acceptance.
REQ-019 SHALL take a fast path for DIV/REM with op_a = most-negative and op_b = -1: quotient op_a, remainder 0, done 1 edge after acceptance.
REQ-020 SHALL treat fun7 != 7'b0000001 as illegal: no CALC, done and illegal high 1 edge after acceptance, result 0.
REQ-021 SHALL keep illegal low for all legal completions; illegal is held with result.
REQ-022 SHALL allow a new start to be accepted in the same cycle done is high (busy low then), giving back-to-back operations.

Reset
REQ-023 SHALL on rst_n=0 immediately force state IDLE, counter 0, busy=0, done=0, illegal=0, result=0.
REQ-024 SHALL abort any in-flight operation on reset with no done pulse; first start after rst_n rises is accepted normally.

Configuration
REQ-025 SHALL compile the divide datapath only when macro ITER_MULDIV_DIV_EN is defined; without it, fun3[2]=1 requests complete as illegal per REQ-020 and MUL ops are unchanged.

Verification
REQ-026 MUL op_a=7, op_b=6, start one cycle -> result=42, done at edge 33, busy high edges 1-32, illegal=0.
REQ-027 MULH 0xFFFFFFFF*0xFFFFFFFF -> 0x00000000; MULHU same -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
REQ-028 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2 (macro defined).
REQ-029 DIVU 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, all with done at edge 1.
REQ-030 fun7=0000000 -> done+illegal at edge 1, result 0; start pulsed mid-CALC ignored; rst_n low at edge 10 of a MUL -> outputs 0, no done; macro undefined, DIV -> illegal.

Source files
------------

// File: rtl/iter_muldiv.sv
// Iterative RV32M-style multiplier/divider: one product or quotient bit per clock.
// Define ITER_MULDIV_DIV_EN to build the divide datapath; otherwise divide ops complete as illegal.
module iter_muldiv #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [6:0]      fun7,
   input  logic [2:0]      fun3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic            illegal
);
   localparam int CW = $clog2(XLEN) + 1;

   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIN = 2'd2} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2:0]        op_q, op_d;
   logic              neg_q, neg_d;
   logic              fast_q, fast_d;
   logic              ill_q, ill_d;
   logic [XLEN-1:0]   opnd_q, opnd_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              illegal_q, illegal_d;
   logic [XLEN-1:0]   result_q, result_d;

   logic              sgn_a, sgn_b, neg_a, neg_b, legal;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next, div_next, res_full;
   logic              div_fast;
   logic [XLEN-1:0]   fast_val, div_res;

   // Operands are reduced to magnitudes; the sign is reapplied once at FIN.
   assign sgn_a = (fun3 == 3'b001) || (fun3 == 3'b010) || (fun3 == 3'b100) || (fun3 == 3'b110);
   assign sgn_b = (fun3 == 3'b001) || (fun3 == 3'b100) || (fun3 == 3'b110);
   assign neg_a = sgn_a & op_a[XLEN-1];
   assign neg_b = sgn_b & op_b[XLEN-1];
   assign mag_a = neg_a ? -op_a : op_a;
   assign mag_b = neg_b ? -op_b : op_b;

   // acc holds {partial product, remaining multiplier bits}; shift right each step.
   assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
   assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
   assign res_full = neg_q ? -acc_q : acc_q;

`ifdef ITER_MULDIV_DIV_EN
   logic [XLEN:0] div_shift, div_diff;

   assign legal     = (fun7 == 7'b0000001);
   // acc holds {remainder, dividend/quotient}; quotient bits enter at the bottom.
   assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
   assign div_diff  = div_shift - {1'b0, opnd_q};
   assign div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                     : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
   assign div_fast  = fun3[2] && ((op_b == '0) ||
                      (sgn_b && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1)));
   assign fast_val  = (op_b == '0) ? (fun3[1] ? op_a : '1) : (fun3[1] ? '0 : op_a);
   assign div_res   = op_q[1] ? (neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN])
                              : res_full[XLEN-1:0];
`else
   assign legal     = (fun7 == 7'b0000001) && !fun3[2];
   assign div_next  = '0;
   assign div_fast  = 1'b0;
   assign fast_val  = '0;
   assign div_res   = '0;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      neg_d     = neg_q;
      fast_d    = fast_q;
      ill_d     = ill_q;
      opnd_d    = opnd_q;
      acc_d     = acc_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      illegal_d = illegal_q;
      result_d  = result_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               op_d   = fun3;
               cnt_d  = '0;
               fast_d = 1'b0;
               ill_d  = 1'b0;
               busy_d = 1'b1;
               neg_d  = (fun3[2] && fun3[1]) ? neg_a : (neg_a ^ neg_b);
               if (!legal) begin
                  ill_d   = 1'b1;
                  state_d = FIN;
               end else if (div_fast) begin
                  fast_d  = 1'b1;
                  acc_d   = {{XLEN{1'b0}}, fast_val};
                  state_d = FIN;
               end else begin
                  opnd_d  = fun3[2] ? mag_b : mag_a;
                  acc_d   = {{XLEN{1'b0}}, (fun3[2] ? mag_a : mag_b)};
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            acc_d = op_q[2] ? div_next : mul_next;
            cnt_d = cnt_q + CW'(1);
            if (cnt_d == CW'(XLEN)) state_d = FIN;
         end
         FIN: begin
            done_d    = 1'b1;
            busy_d    = 1'b0;
            illegal_d = ill_q;
            state_d   = IDLE;
            if (ill_q)                 result_d = '0;
            else if (fast_q)           result_d = acc_q[XLEN-1:0];
            else if (op_q[2])          result_d = div_res;
            else if (op_q[1:0] == 2'b00) result_d = res_full[XLEN-1:0];
            else                       result_d = res_full[2*XLEN-1:XLEN];
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         op_q      <= '0;
         neg_q     <= 1'b0;
         fast_q    <= 1'b0;
         ill_q     <= 1'b0;
         opnd_q    <= '0;
         acc_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         neg_q     <= neg_d;
         fast_q    <= fast_d;
         ill_q     <= ill_d;
         opnd_q    <= opnd_d;
         acc_q     <= acc_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         illegal_q <= illegal_d;
         result_q  <= result_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign result  = result_q;
   assign illegal = illegal_q;
endmodule

// File: tb/tb_iter_muldiv.sv
// Self-checking bench for iter_muldiv (XLEN=32): directed literal cases plus randomized
// traffic compared every cycle against an arithmetic reference model.
module tb_iter_muldiv;
   localparam int XLEN = 32;
`ifdef ITER_MULDIV_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   logic            clk;
   logic            rst_n;
   logic            start;
   logic [6:0]      fun7;
   logic [2:0]      fun3;
   logic [XLEN-1:0] op_a, op_b;
   logic            busy, done, illegal;
   logic [XLEN-1:0] result;

   int total = 0;
   int bad   = 0;

   iter_muldiv #(.XLEN(XLEN)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .fun7(fun7), .fun3(fun3),
      .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result), .illegal(illegal)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: plain 64-bit arithmetic and SV division semantics.
   function automatic void model(input logic [6:0] f7, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic ill, output int lat);
      longint      sa, sb, ub, p;
      logic [63:0] pu;
      int          ia, ib;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ub = longint'({32'b0, b});
      ia = $signed(a);
      ib = $signed(b);
      pu = {32'b0, a} * {32'b0, b};
      r = '0; ill = 1'b0; lat = 33;
      if (f7 != 7'b0000001 || (f3[2] && !DIV_EN)) begin
         ill = 1'b1; lat = 1;
         return;
      end
      case (f3)
         3'd0: r = pu[31:0];
         3'd1: begin p = sa * sb; r = p[63:32]; end
         3'd2: begin p = sa * ub; r = p[63:32]; end
         3'd3: r = pu[63:32];
         3'd4: if (b == 0) begin r = '1; lat = 1; end
               else if (a == 32'h80000000 && b == 32'hffffffff) begin r = a; lat = 1; end
               else r = ia / ib;
         3'd5: if (b == 0) begin r = '1; lat = 1; end
               else r = a / b;
         3'd6: if (b == 0) begin r = a; lat = 1; end
               else if (a == 32'h80000000 && b == 32'hffffffff) begin r = '0; lat = 1; end
               else r = ia % ib;
         default: if (b == 0) begin r = a; lat = 1; end
                  else r = a % b;
      endcase
   endfunction

   // Per-cycle compare process with an expected-result queue.
   logic [32:0] exp_q[$];
   bit          m_busy;
   int          m_left;
   logic [31:0] last_res;
   logic        last_ill;

   always @(posedge clk) begin
      bit          acc, done_exp;
      logic [31:0] r;
      logic        il;
      int          lat;
      logic [32:0] e;
      done_exp = 1'b0;
      if (!rst_n) begin
         m_busy = 1'b0; m_left = 0; exp_q.delete();
         last_res = '0; last_ill = 1'b0;
      end else begin
         acc = (start === 1'b1) && !m_busy;
         if (m_busy) begin
            m_left--;
            if (m_left == 0) begin m_busy = 1'b0; done_exp = 1'b1; end
         end
         if (acc) begin
            model(fun7, fun3, op_a, op_b, r, il, lat);
            m_busy = 1'b1; m_left = lat;
            exp_q.push_back({il, r});
         end
      end
      #1;
      chk("busy", busy, m_busy);
      chk("done", done, done_exp);
      if (done_exp && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("result", result, e[31:0]);
         chk("illegal", illegal, e[32]);
         last_res = e[31:0];
         last_ill = e[32];
      end else if (!m_busy) begin
         chk("result_hold", result, last_res);
         chk("illegal_hold", illegal, last_ill);
      end
   end

   task automatic run_op(input logic [6:0] f7, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input int pulse_at,
                         output logic [31:0] res, output logic ill, output int cyc);
      int n;
      bit seen;
      n = 0;
      while (busy && n < 100) begin @(negedge clk); n++; end
      @(negedge clk);
      start = 1'b1; fun7 = f7; fun3 = f3; op_a = a; op_b = b;
      @(posedge clk);
      cyc = 0; seen = 1'b0; res = '0; ill = 1'b0;
      while (!seen && cyc < 40) begin
         @(negedge clk);
         start = (cyc == pulse_at);
         fun7  = 7'b0000001;
         fun3  = 3'($urandom_range(0, 7));
         op_a  = $urandom();
         op_b  = $urandom();
         @(posedge clk);
         #1;
         cyc++;
         if (done) begin seen = 1'b1; res = result; ill = illegal; end
      end
      if (!seen) chk("op_timeout", 0, 1);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hffffffff;
         3: return 32'h80000000;
         4: return 32'h7fffffff;
         5: return 32'($urandom_range(0, 15));
         default: return $urandom();
      endcase
   endfunction

   initial begin
      logic [31:0] r, er;
      logic        il, eil;
      int          c, elat, n, dones;

      rst_n = 1'b0; start = 1'b0; fun7 = '0; fun3 = '0; op_a = '0; op_b = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_illegal", illegal, 0);
      rst_n = 1'b1;

      run_op(7'h01, 3'b000, 32'd7, 32'd6, -1, r, il, c);
      chk("mul_res", r, 42); chk("mul_cyc", c, 33); chk("mul_ill", il, 0);
      run_op(7'h01, 3'b001, 32'hffffffff, 32'hffffffff, -1, r, il, c);
      chk("mulh_res", r, 32'h0); chk("mulh_cyc", c, 33);
      run_op(7'h01, 3'b011, 32'hffffffff, 32'hffffffff, -1, r, il, c);
      chk("mulhu_res", r, 32'hfffffffe);
      run_op(7'h01, 3'b010, 32'hffffffff, 32'd2, -1, r, il, c);
      chk("mulhsu_res", r, 32'hffffffff);

`ifdef ITER_MULDIV_DIV_EN
      run_op(7'h01, 3'b100, 32'hfffffff9, 32'd2, -1, r, il, c);
      chk("div_res", r, 32'hfffffffd); chk("div_cyc", c, 33);
      run_op(7'h01, 3'b110, 32'hfffffff9, 32'd2, -1, r, il, c);
      chk("rem_res", r, 32'hffffffff);
      run_op(7'h01, 3'b101, 32'd100, 32'd7, -1, r, il, c);
      chk("divu_res", r, 14);
      run_op(7'h01, 3'b111, 32'd100, 32'd7, -1, r, il, c);
      chk("remu_res", r, 2);
      run_op(7'h01, 3'b101, 32'd5, 32'd0, -1, r, il, c);
      chk("divu0_res", r, 32'hffffffff); chk("divu0_cyc", c, 1); chk("divu0_ill", il, 0);
      run_op(7'h01, 3'b110, 32'd5, 32'd0, -1, r, il, c);
      chk("rem0_res", r, 5); chk("rem0_cyc", c, 1);
      run_op(7'h01, 3'b100, 32'h80000000, 32'hffffffff, -1, r, il, c);
      chk("divovf_res", r, 32'h80000000); chk("divovf_cyc", c, 1);
`else
      run_op(7'h01, 3'b100, 32'hfffffff9, 32'd2, -1, r, il, c);
      chk("div_off_ill", il, 1); chk("div_off_res", r, 0); chk("div_off_cyc", c, 1);
`endif

      run_op(7'h00, 3'b000, 32'd5, 32'd3, -1, r, il, c);
      chk("f7_ill", il, 1); chk("f7_res", r, 0); chk("f7_cyc", c, 1);

      // A start pulse during CALC must neither restart nor queue an operation.
      run_op(7'h01, 3'b011, 32'h12345678, 32'h9abcdef0, 10, r, il, c);
      model(7'h01, 3'b011, 32'h12345678, 32'h9abcdef0, er, eil, elat);
      chk("pulse_res", r, er); chk("pulse_cyc", c, 33);

      // Reset in the middle of a multiply: outputs clear at once, no done follows.
      @(negedge clk);
      start = 1'b1; fun7 = 7'h01; fun3 = 3'b000; op_a = 32'd3; op_b = 32'd5;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", busy, 0); chk("arst_done", done, 0);
      chk("arst_result", result, 0); chk("arst_illegal", illegal, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      repeat (40) begin @(posedge clk); #1; if (done) dones++; end
      chk("arst_no_done", dones, 0);
      run_op(7'h01, 3'b000, 32'd9, 32'd9, -1, r, il, c);
      chk("post_rst_res", r, 81); chk("post_rst_cyc", c, 33);
      run_op(7'h01, 3'b000, 32'd11, 32'd12, -1, r, il, c);
      chk("b2b_res", r, 132); chk("b2b_cyc", c, 33);

      for (int i = 0; i < 2500; i++) begin
         @(negedge clk);
         start = ($urandom_range(0, 3) != 0);
         fun7  = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(0, 127)) : 7'b0000001;
         fun3  = 3'($urandom_range(0, 7));
         op_a  = pick();
         op_b  = pick();
      end
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (busy && n < 50) begin @(negedge clk); n++; end
      chk("drain_idle", busy, 0);
      repeat (2) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
